// File: rtl/pc_unit_ras.sv
// pc_unit_ras -- fetch-stage program counter with a return-address stack.
//
// Computes the next fetch address from decode control: sequential,
// relative branch, absolute jump, call (push return address), return
// (pop), and halt. Fetch backpressure holds the unit in place. A small
// FSM inserts one bubble after reset and parks the unit in HALT until
// resume.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_ctl        0 SEQ, 1 BR, 2 JMP, 3 CALL, 4 RET, 5 HALT, 6-7 illegal
//   i_br_taken   BR condition
//   i_offset     signed byte offset for BR/CALL
//   i_target     absolute address for JMP
//   i_fetch_rdy  fetch accepts o_pc this cycle
//   i_resume     leave HALT
//   o_pc         current PC
//   o_pc_valid   o_pc is a valid fetch address
//   o_halted     unit is halted
//   o_ras_cnt    live RAS entries
//   o_ras_ovf    pulse: CALL with RAS full (oldest entry overwritten)
//   o_ras_unf    pulse: RET with RAS empty (PC goes to RESET_VEC)
//   o_illegal    pulse: illegal ctl consumed
//
// state | meaning
// BOOT  | one bubble after reset, pc not valid
// RUN   | fetching, pc advances when fetch accepts it
// HALT  | pc held and not valid until resume

module pc_unit_ras #(
  parameter int unsigned            XLEN      = 32,
  parameter int unsigned            OFFSET_W  = 26,
  parameter int unsigned            INSTR_B   = 4,
  parameter int unsigned            RAS_DEPTH = 4,
  parameter logic [XLEN-1:0]        RESET_VEC = '0,
  localparam int unsigned           PTR_W     = $clog2(RAS_DEPTH),
  localparam int unsigned           CNT_W     = PTR_W + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [2:0]          i_ctl,
  input  logic                i_br_taken,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic [XLEN-1:0]     i_target,
  input  logic                i_fetch_rdy,
  input  logic                i_resume,
  output logic [XLEN-1:0]     o_pc,
  output logic                o_pc_valid,
  output logic                o_halted,
  output logic [CNT_W-1:0]    o_ras_cnt,
  output logic                o_ras_ovf,
  output logic                o_ras_unf,
  output logic                o_illegal
);

  localparam logic [2:0] CTL_SEQ  = 3'd0;
  localparam logic [2:0] CTL_BR   = 3'd1;
  localparam logic [2:0] CTL_JMP  = 3'd2;
  localparam logic [2:0] CTL_CALL = 3'd3;
  localparam logic [2:0] CTL_RET  = 3'd4;
  localparam logic [2:0] CTL_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [PTR_W-1:0]  r_top, w_top_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_ovf, r_unf, r_ill;
  logic              w_ovf, w_unf, w_ill, w_push;
  logic [XLEN-1:0]   w_seq, w_off_sx, w_ras_top;
  logic              w_full, w_empty;

  // RAS storage; r_top points at the next free slot, so when full it also
  // points at the oldest entry and a push overwrites it naturally.
  logic [XLEN-1:0]   r_ras [RAS_DEPTH];

  assign w_seq     = r_pc + XLEN'(INSTR_B);
  assign w_off_sx  = {{(XLEN-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};
  assign w_ras_top = r_ras[r_top - PTR_W'(1)];
  assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_empty   = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_top_nxt   = r_top;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    w_ill       = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_fetch_rdy) begin
          case (i_ctl)
            CTL_SEQ: w_pc_nxt = w_seq;
            CTL_BR:  w_pc_nxt = i_br_taken ? (w_seq + w_off_sx) : w_seq;
            CTL_JMP: w_pc_nxt = i_target;
            CTL_CALL: begin
              w_pc_nxt  = w_seq + w_off_sx;
              w_push    = 1'b1;
              w_top_nxt = r_top + PTR_W'(1);
              if (w_full) w_ovf = 1'b1;
              else        w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            CTL_RET: begin
              if (w_empty) begin
                w_pc_nxt = RESET_VEC;
                w_unf    = 1'b1;
              end else begin
                w_pc_nxt  = w_ras_top;
                w_top_nxt = r_top - PTR_W'(1);
                w_cnt_nxt = r_cnt - CNT_W'(1);
              end
            end
            CTL_HALT: begin
              w_pc_nxt    = w_seq;
              w_state_nxt = ST_HALT;
            end
            default: begin
              w_pc_nxt = w_seq;
              w_ill    = 1'b1;
            end
          endcase
        end
      end
      ST_HALT: if (i_resume) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VEC;
      r_top   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_top   <= w_top_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
      r_ill   <= w_ill;
    end
  end

  // Entries need no reset: the count and pointer alone decide what is live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_ras[r_top] <= w_seq;
  end

  assign o_pc       = r_pc;
  assign o_pc_valid = (r_state == ST_RUN);
  assign o_halted   = (r_state == ST_HALT);
  assign o_ras_cnt  = r_cnt;
  assign o_ras_ovf  = r_ovf;
  assign o_ras_unf  = r_unf;
  assign o_illegal  = r_ill;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HALT = 3'd5, ILL = 3'd6;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ctl;
  logic        br_taken;
  logic [25:0] offset;
  logic [31:0] target;
  logic        fetch_rdy;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid, halted, ras_ovf, ras_unf, illegal;
  logic [2:0]  ras_cnt;

  int errors = 0;
  int checks = 0;

  pc_unit_ras dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctl(ctl), .i_br_taken(br_taken),
    .i_offset(offset), .i_target(target), .i_fetch_rdy(fetch_rdy),
    .i_resume(resume), .o_pc(pc), .o_pc_valid(pc_valid), .o_halted(halted),
    .o_ras_cnt(ras_cnt), .o_ras_ovf(ras_ovf), .o_ras_unf(ras_unf),
    .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  // Reference model: 0 boot, 1 run, 2 halt; stack as a bounded queue.
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_stack.delete();
  endtask

  // Drive one cycle of inputs (caller is in the low clock phase), push the
  // expected post-edge state, then pop and compare after the edge.
  task automatic step(input logic [2:0] c, input logic bt, input logic [25:0] off,
                      input logic [31:0] tgt, input logic rdy, input logic res);
    exp_t        e;
    logic [31:0] seq, sx;
    ctl = c; br_taken = bt; offset = off; target = tgt; fetch_rdy = rdy; resume = res;
    e.ovf = 1'b0; e.unf = 1'b0; e.ill = 1'b0;
    seq = m_pc + 32'd4;
    sx  = {{6{off[25]}}, off};
    case (m_state)
      0: m_state = 1;
      1: if (rdy) begin
        case (c)
          SEQ:  m_pc = seq;
          BR:   m_pc = bt ? seq + sx : seq;
          JMP:  m_pc = tgt;
          CALL: begin
            m_pc = seq + sx;
            if (m_stack.size() == DEPTH) begin
              e.ovf = 1'b1;
              void'(m_stack.pop_front());
            end
            m_stack.push_back(seq);
          end
          RET: begin
            if (m_stack.size() == 0) begin
              m_pc  = 32'h0;
              e.unf = 1'b1;
            end else m_pc = m_stack.pop_back();
          end
          HALT: begin m_pc = seq; m_state = 2; end
          default: begin m_pc = seq; e.ill = 1'b1; end
        endcase
      end
      default: if (res) m_state = 1;
    endcase
    e.pc = m_pc; e.valid = (m_state == 1); e.halted = (m_state == 2);
    e.cnt = 3'(m_stack.size());
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("pc",       pc,       e.pc);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
    chk("halted",   {31'd0, halted},   {31'd0, e.halted});
    chk("ras_cnt",  {29'd0, ras_cnt},  {29'd0, e.cnt});
    chk("ras_ovf",  {31'd0, ras_ovf},  {31'd0, e.ovf});
    chk("ras_unf",  {31'd0, ras_unf},  {31'd0, e.unf});
    chk("illegal",  {31'd0, illegal},  {31'd0, e.ill});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ctl = SEQ; br_taken = 1'b0; offset = '0; target = '0;
    fetch_rdy = 1'b1; resume = 1'b0;
    model_reset();
    #3;
    chk("rst_pc",    pc, 32'h0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_cnt",   {29'd0, ras_cnt},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: boot bubble then sequential fetch
    step(SEQ, 0, '0, '0, 1, 0);
    step(SEQ, 0, '0, '0, 1, 0);
    step(SEQ, 0, '0, '0, 1, 0);
    step(SEQ, 0, '0, '0, 1, 0);

    // T2: branch taken / not taken
    step(JMP, 0, '0, 32'h100, 1, 0);
    step(BR,  1, 26'h3FFFFF8, '0, 1, 0);
    step(JMP, 0, '0, 32'h100, 1, 0);
    step(BR,  0, 26'h3FFFFF8, '0, 1, 0);

    // T3: call / return
    step(JMP,  0, '0, 32'h40, 1, 0);
    step(CALL, 0, 26'h100, '0, 1, 0);
    step(RET,  0, '0, '0, 1, 0);

    // T4: RAS overflow then drain to underflow
    step(JMP, 0, '0, 32'h1000, 1, 0);
    for (int i = 0; i < 5; i++) step(CALL, 0, 26'h10, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(RET, 0, '0, '0, 1, 0);
    step(ILL, 0, '0, '0, 1, 0);
    step(3'd7, 0, '0, '0, 1, 0);

    // T5: stall, halt, resume
    step(JMP, 0, '0, 32'h200, 1, 0);
    for (int i = 0; i < 3; i++) step(JMP, 0, '0, 32'h800, 0, 0);
    step(CALL, 0, 26'h40, '0, 0, 0);
    step(HALT, 0, '0, '0, 1, 0);
    step(JMP, 0, '0, 32'h800, 1, 0);
    step(SEQ, 0, '0, '0, 1, 0);
    step(SEQ, 0, '0, '0, 1, 1);
    step(SEQ, 0, '0, '0, 1, 1);

    // T6: wrap, then async reset while halted with live RAS entries
    step(JMP,  0, '0, 32'hFFFFFFFC, 1, 0);
    step(SEQ,  0, '0, '0, 1, 0);
    step(CALL, 0, 26'h20, '0, 1, 0);
    step(HALT, 0, '0, '0, 1, 0);
    step(SEQ,  0, '0, '0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc",     pc, 32'h0);
    chk("arst_halted", {31'd0, halted},   32'd0);
    chk("arst_valid",  {31'd0, pc_valid}, 32'd0);
    chk("arst_cnt",    {29'd0, ras_cnt},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(SEQ, 0, '0, '0, 1, 0);
    step(RET, 0, '0, '0, 1, 0);
    step(SEQ, 0, '0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
